// File: rtl/prime_factor_engine_pkg.sv
// Shared types and constants for the parallel trial-division prime engine.
package prime_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ISSUE,
        RUN,
        EVAL,
        DONE
    } state_t;

    localparam int unsigned FIRST_DIVISOR = 3;

    // Each round advances the base divisor past every odd candidate the lanes covered.
    function automatic int unsigned lane_stride(input int unsigned lanes);
        return 2 * lanes;
    endfunction

endpackage

// File: rtl/prime_factor_engine_mod_unit.sv
// Restoring shift-subtract remainder: a mod b in WIDTH cycles, the first step taken on the start edge.
module mod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             rem_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             run_reg, run_next;

    logic [WIDTH-1:0] rem_src;
    logic [WIDTH-1:0] div_src;
    logic             bit_src;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;

    always_comb begin
        rem_src = start ? '0 : rem_reg;
        div_src = start ? b : div_reg;
        bit_src = start ? a[WIDTH-1] : shift_reg[WIDTH-1];
        trial   = {rem_src, bit_src};
        // The true difference is below the divisor, so WIDTH-bit wraparound is exact.
        if (trial >= {1'b0, div_src}) begin
            rem_step = trial[WIDTH-1:0] - div_src;
        end else begin
            rem_step = trial[WIDTH-1:0];
        end
    end

    always_comb begin
        rem_next   = rem_reg;
        shift_next = shift_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        run_next   = run_reg;
        if (start) begin
            rem_next   = rem_step;
            shift_next = a << 1;
            div_next   = b;
            cnt_next   = CW'(WIDTH - 1);
            run_next   = 1'b1;
        end else if (run_reg && (cnt_reg != '0)) begin
            rem_next   = rem_step;
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg   <= '0;
            shift_reg <= '0;
            div_reg   <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
        end else begin
            rem_reg   <= rem_next;
            shift_reg <= shift_next;
            div_reg   <= div_next;
            cnt_reg   <= cnt_next;
            run_reg   <= run_next;
        end
    end

    assign done     = run_reg && (cnt_reg == '0);
    assign rem_zero = (rem_reg == '0);

endmodule

// File: rtl/prime_factor_engine.sv
// Prime test by trial division with LANES odd divisors per round; returns primality and smallest factor.
module prime_factor_engine
    import prime_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_i,
    input  logic [WIDTH-1:0] number,
    output logic             valid_o,
    input  logic             ready_o,
    output logic             result,
    output logic [WIDTH-1:0] factor,
    output logic             busy
);

    localparam int DW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] STRIDE = WIDTH'(lane_stride(LANES));
    localparam logic [WIDTH-1:0] FIRST  = WIDTH'(FIRST_DIVISOR);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] n_reg, n_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [WIDTH-1:0] factor_reg, factor_next;
    logic             result_reg, result_next;
    logic             lane_start;

    logic [WIDTH-1:0] cand [LANES];
    logic [LANES-1:0] lane_done;
    logic [LANES-1:0] lane_zero;
    logic [LANES-1:0] lane_hit;
    logic [DW-1:0]    n_ext;

    assign n_ext = {{WIDTH{1'b0}}, n_reg};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] cand_sq;

            assign cand[gi] = d_reg + WIDTH'(2 * gi);
            assign cand_sq  = {{WIDTH{1'b0}}, cand[gi]} * {{WIDTH{1'b0}}, cand[gi]};
            // A divisor above sqrt(n) can only pair with a smaller one already tried.
            assign lane_hit[gi] = lane_zero[gi] && (cand_sq <= n_ext);

            mod_unit #(
                .WIDTH (WIDTH)
            ) u_mod (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (lane_start),
                .a        (n_reg),
                .b        (cand[gi]),
                .done     (lane_done[gi]),
                .rem_zero (lane_zero[gi])
            );
        end
    endgenerate

    logic             hit_any;
    logic [WIDTH-1:0] hit_factor;

    always_comb begin
        hit_any    = 1'b0;
        hit_factor = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_hit[k]) begin
                hit_any    = 1'b1;
                hit_factor = cand[k];
            end
        end
    end

    logic [WIDTH-1:0] d_plus;
    logic [DW-1:0]    d_plus_sq;

    assign d_plus    = d_reg + STRIDE;
    assign d_plus_sq = {{WIDTH{1'b0}}, d_plus} * {{WIDTH{1'b0}}, d_plus};

    always_comb begin
        state_next  = state_reg;
        n_next      = n_reg;
        d_next      = d_reg;
        result_next = result_reg;
        factor_next = factor_reg;
        lane_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    n_next     = number;
                    state_next = PRE;
                end
            end
            PRE: begin
                state_next = DONE;
                if (n_reg < WIDTH'(2)) begin
                    result_next = 1'b0;
                    factor_next = '0;
                end else if (n_reg == WIDTH'(2)) begin
                    result_next = 1'b1;
                    factor_next = WIDTH'(2);
                end else if (!n_reg[0]) begin
                    result_next = 1'b0;
                    factor_next = WIDTH'(2);
                end else if (n_reg <= WIDTH'(8)) begin
                    result_next = 1'b1;
                    factor_next = n_reg;
                end else begin
                    d_next     = FIRST;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                lane_start = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (&lane_done) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (hit_any) begin
                    result_next = 1'b0;
                    factor_next = hit_factor;
                    state_next  = DONE;
                end else begin
                    d_next = d_plus;
                    if (d_plus_sq > n_ext) begin
                        result_next = 1'b1;
                        factor_next = n_reg;
                        state_next  = DONE;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                if (ready_o) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg      <= '0;
            d_reg      <= '0;
            result_reg <= 1'b0;
            factor_reg <= '0;
        end else begin
            n_reg      <= n_next;
            d_reg      <= d_next;
            result_reg <= result_next;
            factor_reg <= factor_next;
        end
    end

    assign ready_i = (state_reg == IDLE);
    assign valid_o = (state_reg == DONE);
    assign busy    = (state_reg != IDLE);
    assign result  = result_reg;
    assign factor  = factor_reg;

endmodule

// File: tb/tb_prime_factor_engine.sv
// Self-checking bench for prime_factor_engine: vector table, scoreboard queue and handshake corner cases.
module tb_prime_factor_engine;

    localparam int WIDTH = 16;
    localparam int LANES = 4;

    logic             clk;
    logic             rst_n;
    logic             valid_i;
    logic             ready_i;
    logic [WIDTH-1:0] number;
    logic             valid_o;
    logic             ready_o;
    logic             result;
    logic [WIDTH-1:0] factor;
    logic             busy;

    prime_factor_engine #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_i (ready_i),
        .number  (number),
        .valid_o (valid_o),
        .ready_o (ready_o),
        .result  (result),
        .factor  (factor),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] num;
        logic             exp_result;
        logic [WIDTH-1:0] exp_factor;
        int               exp_cycle;
    } vec_t;

    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns just after the accept edge.
    task automatic drive_op(input logic [WIDTH-1:0] num, input logic r, input logic [WIDTH-1:0] f,
                            input int cyc);
        vec_t e;
        e.num        = num;
        e.exp_result = r;
        e.exp_factor = f;
        e.exp_cycle  = cyc;
        sb_q.push_back(e);
        valid_i = 1'b1;
        number  = num;
        @(posedge clk);
    endtask

    // Waits for the result, checks it against the scoreboard, optionally stalls, then handshakes.
    task automatic collect(input int hold);
        int   cyc  = 0;
        bit   seen = 0;
        vec_t e;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                valid_i = 1'b0;
                number  = WIDTH'($urandom);
                check("busy_after_accept", busy, 1'b1);
                check("ready_i_after_accept", ready_i, 1'b0);
            end
            if (valid_o) begin
                seen = 1;
                break;
            end
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard: got a result, expected an empty queue");
            return;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout n=%0d: got no valid_o in 2000 cycles, expected cycle %0d",
                     e.num, e.exp_cycle);
            return;
        end
        check($sformatf("result n=%0d", e.num), result, e.exp_result);
        check($sformatf("factor n=%0d", e.num), factor, e.exp_factor);
        check($sformatf("latency n=%0d", e.num), cyc, e.exp_cycle);
        $display("n=%0d result=%0d factor=%0d cycle=%0d", e.num, result, factor, cyc);
        for (int h = 0; h < hold; h++) begin
            valid_i = 1'($urandom);
            number  = WIDTH'($urandom);
            @(negedge clk);
            check("hold_valid_o", valid_o, 1'b1);
            check("hold_result", result, e.exp_result);
            check("hold_factor", factor, e.exp_factor);
            check("hold_ready_i", ready_i, 1'b0);
        end
        valid_i = 1'b0;
        ready_o = 1'b1;
        @(posedge clk);
        #1 ready_o = 1'b0;
        @(negedge clk);
        check("post_ready_i", ready_i, 1'b1);
        check("post_valid_o", valid_o, 1'b0);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{16'd1,     1'b0, 16'd0,     2};
        vecs[1]  = '{16'd2,     1'b1, 16'd2,     2};
        vecs[2]  = '{16'd0,     1'b0, 16'd0,     2};
        vecs[3]  = '{16'd4,     1'b0, 16'd2,     2};
        vecs[4]  = '{16'd7,     1'b1, 16'd7,     2};
        vecs[5]  = '{16'd91,    1'b0, 16'd7,     20};
        vecs[6]  = '{16'd65535, 1'b0, 16'd3,     20};
        vecs[7]  = '{16'd25,    1'b0, 16'd5,     20};
        vecs[8]  = '{16'd97,    1'b1, 16'd97,    20};
        vecs[9]  = '{16'd15,    1'b0, 16'd3,     20};
        vecs[10] = '{16'd49,    1'b0, 16'd7,     20};
        vecs[11] = '{16'd121,   1'b0, 16'd11,    38};
        vecs[12] = '{16'd529,   1'b0, 16'd23,    56};
        vecs[13] = '{16'd65521, 1'b1, 16'd65521, 578};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_o = 1'b0;
        number  = '0;
        repeat (2) @(negedge clk);
        check("reset_ready_i", ready_i, 1'b1);
        check("reset_valid_o", valid_o, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_result", result, 1'b0);
        check("reset_factor", factor, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            drive_op(vecs[i].num, vecs[i].exp_result, vecs[i].exp_factor, vecs[i].exp_cycle);
            collect(0);
        end

        // Downstream stall: outputs must hold and new requests must be refused.
        drive_op(16'd91, 1'b0, 16'd7, 20);
        collect(10);

        // Reset in the middle of a long search discards it without any output.
        valid_i = 1'b1;
        number  = 16'd65521;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (30) @(negedge clk);
        check("midrun_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_rst_valid_o", valid_o, 1'b0);
        check("midrun_rst_ready_i", ready_i, 1'b1);
        check("midrun_rst_factor", factor, 16'd0);
        check("midrun_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_op(16'd9, 1'b0, 16'd3, 20);
        collect(0);

        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/prime_factor_engine.md
Name: prime_factor_engine

Overview:
Parametrised successor to the single-lane prime checker. It accepts an unsigned integer over a valid/ready handshake and tests it by trial division with LANES odd divisors in parallel per round. It returns a primality flag and the smallest nontrivial factor. It sits behind the same upstream producer and downstream consumer handshakes as the existing checker.

Parameters:
WIDTH, 32, operand width in bits; even, >= 8
LANES, 4, parallel trial-division lanes per round; power of 2, 1..16

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  upstream request valid
ready_i  output  1  engine can accept; high only in IDLE
number  input  WIDTH  operand, sampled on the accept edge only
valid_o  output  1  result valid; high only in DONE
ready_o  input  1  downstream accepts result
result  output  1  1 = number is prime
factor  output  WIDTH  smallest factor > 1; equals number if prime; 0 if number < 2
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state): state = IDLE; ready_i = 1; valid_o = 0; result = 0; factor = 0; busy = 0. Any in-flight operation is discarded with no output.
- Accept occurs on the clk edge where valid_i && ready_i. number is latched into internal register n. The input is never read again, so upstream may change it freely.
- States: IDLE, PRE, ISSUE, RUN, EVAL, DONE.
- IDLE -> PRE on accept.
- PRE resolves trivial cases, then goes to DONE or ISSUE:
  - n < 2 -> result 0, factor 0.
  - n == 2 -> result 1, factor 2.
  - n even and > 2 -> result 0, factor 2.
  - n odd and 3..8 -> result 1, factor n.
  - Otherwise: base d = 3, go to ISSUE.
- ISSUE (1 cycle): lane k gets candidate c_k = d + 2k, for k = 0..LANES-1. Each mod_unit receives a one-cycle start. Go to RUN.
- RUN: wait for all lanes to assert done. Latency is exactly WIDTH cycles after start. Then go to EVAL.
- EVAL (1 cycle):
  - Lane k hits if its remainder is 0 and c_k*c_k <= n. Squares are computed at 2*WIDTH bits.
  - Lanes with c_k*c_k > n are masked.
  - Any hit -> result 0, factor = c_k of the lowest-index hit, go to DONE.
  - Else d <= d + 2*LANES. If the new d squared > n -> result 1, factor n, go to DONE. Otherwise go to ISSUE.
- DONE: valid_o = 1. result and factor are held stable until ready_o. On valid_o && ready_o -> IDLE, with ready_i high the following cycle. valid_o must not drop without ready_o.
- Latency, counted with the accept edge as cycle 0:
  - valid_o first high at cycle 2 for PRE-resolved cases.
  - Otherwise at cycle 2 + R*(WIDTH+2), where R = number of rounds.
- Candidate register d is WIDTH bits. Overflow is impossible, because the loop terminates once d squared exceeds n < 2^WIDTH.
- result and factor are updated only on entry to DONE. They retain their values in IDLE until the next result.
- No new accept while busy: ready_i = 0 outside IDLE, including the DONE cycle where ready_o is high.

Decomposition:
- Package prime_pkg holds:
  - the state enum (IDLE, PRE, ISSUE, RUN, EVAL, DONE);
  - a localparam for the first odd divisor (3);
  - a function for the lane stride (2*LANES).
- Sub-module mod_unit:
  - WIDTH-cycle restoring remainder (shift-subtract) computing a mod b;
  - ports clk, rst_n, start, a, b, done, rem_zero;
  - instantiated LANES times via a generate loop.

Test Plan:
- WIDTH=16, LANES=4, number=1 then number=2 -> (result 0, factor 0) and (result 1, factor 2); valid_o at cycle 2 for each.
- number=91 -> result 0, factor 7 (first round, lanes 3/5/7/9); valid_o at cycle 20. number=65535 -> factor 3, also cycle 20.
- number=25 -> factor 5 (lane 7 masked since 49 > 25). number=97 -> result 1, factor 97, cycle 20.
- number=65521 (largest 16-bit prime) -> result 1, factor 65521, valid_o at cycle 2 + 32*18 = 578.
- Backpressure: hold ready_o=0 for 10 cycles in DONE -> valid_o, result and factor stable; ready_i=0; toggling valid_i/number ignored. Then ready_o=1 -> IDLE next cycle.
- Assert rst_n=0 mid-RUN on number=65521 -> next cycle valid_o=0, ready_i=1, factor=0. A following number=9 returns factor 3 at cycle 20.
